// File: rtl/med_impulse_gate.sv
// Replaces impulses in a raw stream with the median of its 5-tap window, and counts them.
// Latency: 3 edges from dI capture to dO. No backpressure: one sample is accepted every clock.
module med_impulse_gate #(
  parameter int W       = 8,
  parameter int CW      = 16,
  parameter int RUN_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  dI,
  input  logic [W-1:0]  tap,
  input  logic [W-1:0]  thr,
  input  logic          clr,
  output logic [W-1:0]  dO,
  output logic          vO,
  output logic          imp,
  output logic [CW-1:0] impCnt,
  output logic          alarm
);

  typedef enum logic [1:0] {IDLE, RUN, ALARM} state_t;

  localparam logic [3:0]    RUN_LIM = 4'(RUN_MAX);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [W-1:0] d0, d1, d2;
  logic [2:0]   wc;
  logic         active;
  logic [W-1:0] diff;
  logic         hit;
  state_t       state, state_nxt;
  logic [3:0]   run, run_nxt, run_inc;

  assign active  = (wc == 3'd5);
  assign hit     = active && (diff > thr);
  assign run_inc = (run == 4'hF) ? run : run + 4'd1;

  // d2 lines up with the centre of the window that produced tap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0 <= '0;
      d1 <= '0;
      d2 <= '0;
      wc <= '0;
    end else begin
      d0 <= dI;
      d1 <= d0;
      d2 <= d1;
      if (wc != 3'd5) wc <= wc + 3'd1;
    end
  end

  always_comb begin
    if (d2 >= tap) diff = d2 - tap;
    else           diff = tap - d2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dO  <= '0;
      imp <= 1'b0;
      vO  <= 1'b0;
    end else if (active) begin
      dO  <= hit ? tap : d2;
      imp <= hit;
      vO  <= 1'b1;
    end
  end

  // clr outranks a coincident hit: the hit is still output but never counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      impCnt <= '0;
    end else if (clr) begin
      impCnt <= '0;
    end else if (hit && (impCnt != CNT_MAX)) begin
      impCnt <= impCnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      run   <= '0;
    end else begin
      state <= state_nxt;
      run   <= run_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    if (clr) begin
      state_nxt = IDLE;
      run_nxt   = '0;
    end else if (active) begin
      case (state)
        IDLE: begin
          if (hit) begin
            run_nxt   = 4'd1;
            state_nxt = (RUN_LIM == 4'd1) ? ALARM : RUN;
          end
        end
        RUN: begin
          if (hit) begin
            run_nxt = run_inc;
            if (run_inc >= RUN_LIM) state_nxt = ALARM;
          end else begin
            run_nxt   = '0;
            state_nxt = IDLE;
          end
        end
        ALARM: begin
          run_nxt = hit ? run_inc : 4'd0;
        end
        default: begin
          state_nxt = IDLE;
          run_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    alarm = (state == ALARM);
  end

endmodule

// File: tb/tb_med_impulse_gate.sv
module tb_med_impulse_gate;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dI, tap, thr;
  logic       clr;

  logic [7:0]  dO_a, dO_b;
  logic        vO_a, vO_b, imp_a, imp_b, alarm_a, alarm_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  med_impulse_gate #(.W(8), .CW(16), .RUN_MAX(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .dI(dI), .tap(tap), .thr(thr), .clr(clr),
    .dO(dO_a), .vO(vO_a), .imp(imp_a), .impCnt(cnt_a), .alarm(alarm_a)
  );

  med_impulse_gate #(.W(8), .CW(4), .RUN_MAX(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .dI(dI), .tap(tap), .thr(thr), .clr(clr),
    .dO(dO_b), .vO(vO_b), .imp(imp_b), .impCnt(cnt_b), .alarm(alarm_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference: sample history since reset release, plus expected outputs
  int xs[$];
  int k;
  int exp_dO, exp_imp, exp_vO;
  int cnt_ma, cnt_mb, consec, al_a, al_b;

  function automatic int xv(int j);
    if (j < 1 || j > xs.size()) return 0;
    return xs[j-1];
  endfunction

  function automatic int med5(int c);
    int v[5];
    int t;
    for (int i = 0; i < 5; i++) v[i] = xv(c - 4 + i);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 4 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return v[2];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dO_a"},  32'(dO_a),    32'(exp_dO));
    check({tag, ".imp_a"}, 32'(imp_a),   32'(exp_imp));
    check({tag, ".vO_a"},  32'(vO_a),    32'(exp_vO));
    check({tag, ".cnt_a"}, 32'(cnt_a),   32'(cnt_ma));
    check({tag, ".al_a"},  32'(alarm_a), 32'(al_a));
    check({tag, ".dO_b"},  32'(dO_b),    32'(exp_dO));
    check({tag, ".imp_b"}, 32'(imp_b),   32'(exp_imp));
    check({tag, ".vO_b"},  32'(vO_b),    32'(exp_vO));
    check({tag, ".cnt_b"}, 32'(cnt_b),   32'(cnt_mb));
    check({tag, ".al_b"},  32'(alarm_b), 32'(al_b));
  endtask

  // One clock: present x(k+1) on dI and median(x(k-4..k)) on tap, then verify
  task automatic tick(input int s, input logic c);
    int  m, ctr, dif;
    logic act, h;
    act = (k >= 5);
    m   = med5(k);
    ctr = xv(k - 2);
    dif = (ctr >= m) ? ctr - m : m - ctr;
    h   = act && (dif > int'(thr));
    dI  = 8'(s);
    tap = 8'(m);
    clr = c;
    @(posedge clk);
    #1;
    xs.push_back(s);
    k++;
    if (act) begin
      exp_dO  = h ? m : ctr;
      exp_imp = h ? 1 : 0;
      exp_vO  = 1;
    end
    if (c) begin
      cnt_ma = 0; cnt_mb = 0; consec = 0; al_a = 0; al_b = 0;
    end else if (h) begin
      if (cnt_ma < 65535) cnt_ma++;
      if (cnt_mb < 15) cnt_mb++;
      consec++;
      if (consec >= 3) al_a = 1;
      if (consec >= 2) al_b = 1;
    end else if (act) begin
      consec = 0;
    end
    check_all("step");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dI = '0; tap = '0; clr = 1'b0;
    #1;
    exp_dO = 0; exp_imp = 0; exp_vO = 0;
    cnt_ma = 0; cnt_mb = 0; consec = 0; al_a = 0; al_b = 0;
    check_all("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    xs.delete();
    k = 0;
  endtask

  int v, s, burst;

  initial begin
    rst_n = 1'b1; dI = '0; tap = '0; thr = 8'd4; clr = 1'b0; k = 0;
    #2;
    do_reset();

    // Ramp with a single spike at sample 50
    for (int n = 1; n <= 70; n++) begin
      tick((n == 50) ? 255 : n, 1'b0);
      if (n == 5) check("warm_vO", 32'(vO_a), 32'd0);
      if (n == 6) begin
        check("first_vO", 32'(vO_a), 32'd1);
        check("first_dO", 32'(dO_a), 32'd3);
      end
      if (n == 40) check("ramp_dO", 32'(dO_a), 32'd37);
      if (n == 53) begin
        check("spike_dO",  32'(dO_a),    32'd51);
        check("spike_imp", 32'(imp_a),   32'd1);
        check("spike_cnt", 32'(cnt_a),   32'd1);
        check("spike_al",  32'(alarm_a), 32'd0);
      end
    end

    // Threshold boundary: diff of 9 against thr 9 then thr 8
    do_reset();
    thr = 8'd9;
    for (int n = 1; n <= 60; n++) begin
      tick((n == 50) ? 60 : n, 1'b0);
      if (n == 53) begin
        check("thr9_dO",  32'(dO_a),  32'd60);
        check("thr9_imp", 32'(imp_a), 32'd0);
      end
    end
    do_reset();
    thr = 8'd8;
    for (int n = 1; n <= 60; n++) begin
      tick((n == 50) ? 60 : n, 1'b0);
      if (n == 53) begin
        check("thr8_dO",  32'(dO_a),  32'd51);
        check("thr8_imp", 32'(imp_a), 32'd1);
      end
    end

    // Two-sample burst: alarms dut_b (RUN_MAX 2) but not dut_a (RUN_MAX 3)
    do_reset();
    thr = 8'd4;
    for (int n = 1; n <= 77; n++) begin
      tick((n == 50 || n == 51) ? 255 : n, n == 77);
      if (n == 53) check("burst_dO1", 32'(dO_b), 32'd52);
      if (n == 54) begin
        check("burst_dO2",  32'(dO_b),    32'd53);
        check("burst_imp2", 32'(imp_b),   32'd1);
        check("burst_alb",  32'(alarm_b), 32'd1);
        check("burst_ala",  32'(alarm_a), 32'd0);
      end
      if (n == 76) check("burst_hold", 32'(alarm_b), 32'd1);
      if (n == 77) begin
        check("burst_clr_al",  32'(alarm_b), 32'd0);
        check("burst_clr_cnt", 32'(cnt_b),   32'd0);
      end
    end

    // clr coincident with a hit, then 20 isolated spikes saturate the 4-bit counter
    do_reset();
    for (int n = 1; n <= 140; n++) begin
      s = (n == 50 || (n >= 60 && n <= 136 && n % 4 == 0)) ? 255 : n;
      tick(s, n == 53);
      if (n == 53) begin
        check("coll_dO",  32'(dO_b),  32'd51);
        check("coll_imp", 32'(imp_b), 32'd1);
        check("coll_cnt", 32'(cnt_b), 32'd0);
      end
    end
    check("sat_cnt_b", 32'(cnt_b), 32'd15);
    check("sat_cnt_a", 32'(cnt_a), 32'd20);

    // Reset mid-stream at sample 30
    do_reset();
    for (int n = 1; n <= 29; n++) tick((n == 20) ? 255 : n, 1'b0);
    do_reset();
    for (int n = 1; n <= 10; n++) begin
      tick(n, 1'b0);
      if (n == 5) check("rst_warm_vO", 32'(vO_a), 32'd0);
      if (n == 6) begin
        check("rst_vO",  32'(vO_a),    32'd1);
        check("rst_cnt", 32'(cnt_a),   32'd0);
        check("rst_al",  32'(alarm_b), 32'd0);
      end
    end

    // Randomised stream: wandering signal, spike bursts, random thr and clr
    do_reset();
    v = 128;
    burst = 0;
    for (int n = 1; n <= 1500; n++) begin
      if (n % 100 == 1) thr = 8'($urandom_range(0, 40));
      if (n == 700) do_reset();
      v = v + int'($urandom_range(0, 6)) - 3;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      if (burst == 0 && $urandom_range(0, 14) == 0) burst = $urandom_range(1, 4);
      if (burst > 0) begin
        s = $urandom_range(0, 255);
        burst--;
      end else begin
        s = v;
      end
      tick(s, $urandom_range(0, 63) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/med_impulse_gate.md
# med_impulse_gate

Downstream stage of the 5-tap median filter. Receives the raw sample stream and the filter's median output `tap`. Delays the raw stream to line up with the median window centre and flags a sample as an impulse when it deviates from the median by more than a threshold. Emits a cleaned stream (raw sample, or the median when an impulse is flagged), with a valid strobe, an impulse counter and a sticky burst alarm.

## Interface
- `W`, 8, sample width; must match the median filter data width.
- `CW`, 16, impulse counter width.
- `RUN_MAX`, 3, consecutive impulses that raise `alarm`; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low. Must be the same net that resets the median filter.
- `dI`  in  W  raw sample; the same net that drives the median filter, one new sample every clock.
- `tap`  in  W  median filter output: median of the 5 most recent samples.
- `thr`  in  W  impulse threshold, unsigned, quasi-static. Changes take effect on the next compare.
- `clr`  in  1  synchronous clear of `impCnt`, the run counter and `alarm`.
- `dO`  out  W  cleaned sample, registered.
- `vO`  out  1  `dO` valid, registered.
- `imp`  out  1  the current `dO` is a replaced (median) value.
- `impCnt`  out  CW  total impulses since reset or `clr`; saturates.
- `alarm`  out  1  sticky burst alarm.

## Operation
- **Delay line.** `d0..d2` (W bits each) shift every clock: `d0<=dI`, `d1<=d0`, `d2<=d1`. Cleared to 0 on reset.
  - After edge k, `d2 = x(k-2)` and `tap = median(x(k-4..k))`, so `d2` is the window centre.
- **Warm-up.**
  - Warm-up counter `wc` (3 bits) counts edges after reset release and saturates at 5.
  - State WARM while `wc<5`; ACTIVE once `wc==5`.
  - In WARM, the compare result is discarded: `vO`, `imp`, counters and alarm are not updated, and `dO` stays 0.
- **Compare** (combinational, each cycle in ACTIVE):
  - `diff = (d2>=tap) ? d2-tap : tap-d2`, W bits unsigned, no overflow.
  - `hit = diff > thr`, strict; `diff==thr` is not an impulse.
- **Output register** (in ACTIVE):
  - `dO <= hit ? tap : d2`
  - `imp <= hit`
  - `vO <= 1`
- **Counter.** On `hit`, `impCnt` increments and saturates at 2^CW-1.
- **Burst FSM** (run counter `run`, 4 bits):
  - IDLE: `hit` → RUN, `run=1`; if `RUN_MAX==1`, go directly to ALARM instead.
  - RUN:
    - `hit` → `run+1`; on reaching `RUN_MAX` → ALARM and set `alarm`.
    - `!hit` → IDLE, `run=0`.
  - ALARM: `alarm` held at 1. `run` tracks consecutive hits but has no effect. Only `clr` or reset leaves ALARM (→ IDLE).
- **`clr`.**
  - Clears `impCnt`, `run` and `alarm`, and forces the FSM to IDLE.
  - `clr` wins over a simultaneous `hit`: that hit is neither counted nor starts a run. Its `dO`/`imp` are still produced normally.
  - `clr` has no effect on the delay line, `wc`, `dO` or `vO`.
- **Reset mid-operation.**
  - All state and outputs go to 0 immediately.
  - Warm-up restarts, so `vO` stays 0 for the next 5 edges after release.

## Timing
- Reset values: `dO=0`, `vO=0`, `imp=0`, `impCnt=0`, `alarm=0`, FSM=IDLE, `wc=0`.
- Latency: sample `x(n)` captured at edge n appears on `dO` after edge n+3.
- First `vO=1` occurs after the 6th edge following reset release, carrying `x(3)`.
  - `x(1)` and `x(2)` are never output.
  - `vO` then stays 1 every cycle until reset.
- `impCnt`, `imp`, `dO` and `alarm` update on the same edge as the flagged sample's output.
- No back-pressure; the block accepts one sample per clock, unconditionally.

## Test plan
1. **Ramp.** Median filter instantiated in the bench, `dI = 1,2,3,…`, `thr=4`.
   - `dO` equals `dI` delayed 3 edges, first valid value 3.
   - `imp` stays 0; `impCnt` stays 0.
2. **Single spike.** Ramp with `x(50)=255`, `thr=4`.
   - Slot for sample 50: `dO=51` (median of 48,49,255,51,52), `imp=1`, `impCnt=1`.
   - `alarm=0` when `RUN_MAX=3`.
3. **Threshold boundary.** Ramp with `x(50)=60`, where median is 51 and `diff=9`.
   - `thr=9` → `dO=60`, `imp=0`.
   - `thr=8` → `dO=51`, `imp=1`.
4. **Burst.** `RUN_MAX=2`, ramp with `x(50)=x(51)=255`.
   - Outputs 52 then 53, `imp=1` on both.
   - `alarm` rises with the second output and stays 1 through 20 more clean samples.
   - A `clr` pulse drops `alarm` and `impCnt` to 0.
5. **`clr` collision and saturation.** `CW=4`, with `clr` pulsed on the same edge as a hit.
   - The hit produces `dO=median`, `imp=1`, and `impCnt=0` afterwards.
   - Then 20 isolated spikes (every 4th sample) → `impCnt` stops at 15.
6. **Reset mid-stream.** Assert `rst_n=0` for 2 clocks at sample 30.
   - All outputs read 0 asynchronously.
   - After release: `vO=0` for 5 edges, then 1 on the 6th.
   - `impCnt=0`, `alarm=0`.
